// File: rtl/ins_fetch_queue.sv
// Instruction fetch unit: one outstanding icache fetch, branch-predictor lookup on return, and a circular instruction queue.
// Latency: entry visible on iq_valid one cycle after its cache response; next fetch presented in that same cycle.
// Backpressure: no fetch issued while the queue is full, rdy is low, or a redirect is active; iq_ready pops the head.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   rdy                             global enable, low freezes all state
//   icache_req_valid/ready/pc       fetch request handshake and address
//   icache_resp_valid/instr         returned instruction
//   pred_pc/pred_instr              returning PC/instruction to predictor
//   pred_next_pc/pred_taken         predictor answer, same cycle
//   redirect_valid/pc               rollback: flush queue, refetch from redirect_pc
//   iq_valid/ready/instr/pc/pred_taken/count   queue head towards issue
module ins_fetch_queue #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     ILEN        = 32,
    parameter int unsigned     QUEUE_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    output logic                         icache_req_valid,
    output logic [XLEN-1:0]              icache_req_pc,
    input  logic                         icache_req_ready,
    input  logic                         icache_resp_valid,
    input  logic [ILEN-1:0]              icache_resp_instr,
    output logic [XLEN-1:0]              pred_pc,
    output logic [ILEN-1:0]              pred_instr,
    input  logic [XLEN-1:0]              pred_next_pc,
    input  logic                         pred_taken,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         iq_valid,
    input  logic                         iq_ready,
    output logic [ILEN-1:0]              iq_instr,
    output logic [XLEN-1:0]              iq_pc,
    output logic                         iq_pred_taken,
    output logic [$clog2(QUEUE_DEPTH):0] iq_count
);

    localparam int unsigned PW   = $clog2(QUEUE_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   fetch_pc, fetch_pc_nxt;
    logic [PW-1:0]     head, tail;
    logic [PW:0]       count;
    logic              push, pop, flush;

    logic [ILEN-1:0]        q_instr [QUEUE_DEPTH];
    logic [XLEN-1:0]        q_pc    [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] q_taken;

    // Request is also masked during reset so nothing leaves while rst is held.
    always_comb begin
        state_nxt        = state;
        fetch_pc_nxt     = fetch_pc;
        push             = 1'b0;
        flush            = rdy & redirect_valid;
        icache_req_valid = ~rst & rdy & (state == IDLE) & (count < FULL) & ~redirect_valid;
        iq_valid         = rdy & (count != '0) & ~redirect_valid;
        pop              = iq_valid & iq_ready;

        if (rdy) begin
            if (redirect_valid) begin
                fetch_pc_nxt = redirect_pc;
                // An outstanding fetch is stale; if its response is here now, it is dropped on the spot.
                case (state)
                    WAIT, DROP: state_nxt = icache_resp_valid ? IDLE : DROP;
                    default:    state_nxt = IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (icache_req_valid && icache_req_ready)
                            state_nxt = WAIT;
                    end
                    WAIT: begin
                        if (icache_resp_valid) begin
                            push         = 1'b1;
                            fetch_pc_nxt = pred_next_pc;
                            state_nxt    = IDLE;
                        end
                    end
                    DROP: begin
                        if (icache_resp_valid)
                            state_nxt = IDLE;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    // Pointers wrap naturally since QUEUE_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= icache_resp_instr;
            q_pc[tail]    <= fetch_pc;
            q_taken[tail] <= pred_taken;
        end
    end

    assign icache_req_pc = fetch_pc;
    assign pred_pc       = fetch_pc;
    assign pred_instr    = icache_resp_instr;
    assign iq_instr      = q_instr[head];
    assign iq_pc         = q_pc[head];
    assign iq_pred_taken = q_taken[head];
    assign iq_count      = count;

endmodule
